// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX memory arbiter slice.
package dlx_pkg;
  localparam int WORD = 32;
  localparam logic [WORD-1:0] NOP = 32'h0800_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } arb_state_e;
endpackage

// File: rtl/dlx_arb_fair.sv
// Grant decision between fetch and data channels, with a bounded run of
// data grants while a fetch is waiting.
module dlx_arb_fair #(
  parameter int FAIR_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req_eff,
  input  logic d_req_eff,
  output logic grant_i,
  output logic grant_d
);
  localparam int CW = $clog2(FAIR_MAX + 1);

  logic [CW-1:0] dlx_grant_cnt;

  // Data wins unless a fetch has already waited through FAIR_MAX data grants.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!arb_en) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end else if (d_req_eff && (!i_req_eff || (dlx_grant_cnt < CW'(FAIR_MAX)))) begin
      grant_d = 1'b1;
    end else if (i_req_eff) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Count data grants that overtook a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dlx_grant_cnt <= '0;
    end else if (grant_i) begin
      dlx_grant_cnt <= '0;
    end else if (grant_d && i_req_eff && (dlx_grant_cnt != CW'(FAIR_MAX))) begin
      dlx_grant_cnt <= dlx_grant_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/dlx_mem_arbiter.sv
// Shares one memory port between the DLX fetch and MEM stages, one transaction
// outstanding at a time, with a timeout that aborts a hung access.
module dlx_mem_arbiter
  import dlx_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int FAIR_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [WORD-1:0] i_addr,
  output logic [WORD-1:0] i_rdata,
  output logic            i_valid,
  output logic            stall_if,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic [WORD-1:0] d_rdata,
  output logic            d_valid,
  output logic            stall_mem,
  output logic            m_req,
  output logic            m_we,
  output logic [WORD-1:0] m_addr,
  output logic [WORD-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [WORD-1:0] m_rdata,
  output logic            bus_err
);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_e    state_r;
  logic [WW-1:0] wait_cnt_r;
  logic          i_req_eff_s;
  logic          d_req_eff_s;
  logic          grant_i_s;
  logic          grant_d_s;
  logic          timeout_s;

  // A channel completing this cycle must not be re-granted on its stale request.
  assign i_req_eff_s = i_req & ~i_valid;
  assign d_req_eff_s = d_req & ~d_valid;
  assign timeout_s   = (wait_cnt_r == WW'(TIMEOUT - 1));
  assign stall_if    = i_req & ~i_valid;
  assign stall_mem   = d_req & ~d_valid;

  dlx_arb_fair #(.FAIR_MAX(FAIR_MAX)) u_fair (
    .clk       (clk),
    .reset     (reset),
    .arb_en    (state_r == ST_IDLE),
    .i_req_eff (i_req_eff_s),
    .d_req_eff (d_req_eff_s),
    .grant_i   (grant_i_s),
    .grant_d   (grant_d_s)
  );

  // Transaction FSM: launch on grant, complete on m_ack or abort on timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= NOP;
      d_rdata    <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wait_cnt_r <= '0;
          if (grant_d_s) begin
            state_r <= ST_D_BUSY;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (grant_i_s) begin
            state_r <= ST_I_BUSY;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
          end
        end
        ST_I_BUSY: begin
          if (m_ack || timeout_s) begin
            state_r <= ST_IDLE;
            m_req   <= 1'b0;
            i_valid <= 1'b1;
            i_rdata <= m_ack ? m_rdata : NOP;
            bus_err <= bus_err | ~m_ack;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        ST_D_BUSY: begin
          if (m_ack || timeout_s) begin
            state_r <= ST_IDLE;
            m_req   <= 1'b0;
            d_valid <= 1'b1;
            bus_err <= bus_err | ~m_ack;
            // Stores leave the last load value in place; an aborted access reads as zero.
            if (!m_ack) begin
              d_rdata <= '0;
            end else if (!m_we) begin
              d_rdata <= m_rdata;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          m_req   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/dlx_mem_arbiter.md
DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, max wait cycles for m_ack before abort.
REQ-002 Parameter FAIR_MAX, default 4, consecutive data grants allowed while fetch is waiting.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  fetch request; held high until i_valid.
REQ-006 i_addr  in  32  fetch address; stable while i_req.
REQ-007 i_rdata  out  32  fetched instruction; valid when i_valid.
REQ-008 i_valid  out  1  one-cycle fetch completion pulse.
REQ-009 stall_if  out  1  IF stage must hold PC.
REQ-010 d_req  in  1  data request from MEM stage; held high until d_valid.
REQ-011 d_we  in  1  1=store, 0=load; stable while d_req.
REQ-012 d_addr, d_wdata  in  32 each  data address and store data; stable while d_req.
REQ-013 d_rdata  out  32  load data; valid when d_valid.
REQ-014 d_valid  out  1  one-cycle data completion pulse (loads and stores).
REQ-015 stall_mem  out  1  pipeline from MEM backwards must freeze.
REQ-016 m_req, m_we  out  1 each  shared memory port request and write enable.
REQ-017 m_addr, m_wdata  out  32 each  shared memory port address and write data.
REQ-018 m_ack  in  1  memory completion, any latency >=1 cycle after m_req.
REQ-019 m_rdata  in  32  read data, valid with m_ack.
REQ-020 bus_err  out  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, I_BUSY, D_BUSY; exactly one memory transaction outstanding.
REQ-022 IDLE: grant D if d_req and (not i_req or dgrant_cnt<FAIR_MAX); else grant I if i_req; else stay.
REQ-023 dgrant_cnt increments on each D grant while i_req high, clears on any I grant, saturates at FAIR_MAX.
REQ-024 On grant, m_req, m_we, m_addr, m_wdata are registered from the granted channel and appear the next cycle (m_we=0 for I).
REQ-025 m_req and m_addr/m_we/m_wdata stay constant from assertion until the cycle m_ack is sampled high.
REQ-026 m_ack sampled high in I_BUSY/D_BUSY: m_req low next cycle, m_rdata captured into i_rdata/d_rdata, matching valid high for exactly one cycle, FSM to IDLE.
REQ-027 d_rdata unchanged on store completion; d_valid still pulses.
REQ-028 In the cycle a channel's valid is high, that channel's req is ignored for arbitration; other channel may be granted.
REQ-029 Minimum request-to-valid latency: 3 cycles with m_ack one cycle after m_req.
REQ-030 stall_if = i_req and not i_valid; stall_mem = d_req and not d_valid; combinational.
REQ-031 m_ack while IDLE is ignored.
REQ-032 Wait counter clears on grant, counts each BUSY cycle without m_ack; reaching TIMEOUT: drop m_req, set bus_err, pulse valid with i_rdata=NOP (32'h08000000) or d_rdata=0, go IDLE.
REQ-033 bus_err clears only on reset.

Reset
REQ-034 reset asserted: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=NOP, d_rdata=0, i_valid=0, d_valid=0, bus_err=0, counters=0, immediately (asynchronous).
REQ-035 Reset mid-transaction abandons it; a later m_ack for it is ignored per REQ-031.

Structure
REQ-036 Shared package dlx_pkg holds state enum, NOP constant, WORD width constant.
REQ-037 Sub-module dlx_arb_fair holds dlx_grant_cnt and grant decision; datapath/FSM stay in top.

Verification
REQ-038 Fetch only: i_req, i_addr=0x100, m_ack 1 cycle after m_req, m_rdata=0x20010005 -> i_valid on cycle 3, i_rdata=0x20010005, stall_if high cycles 0-2.
REQ-039 Simultaneous i_req and d_req (load 0x200) -> D served first, then I; m_addr 0x200 then I address.
REQ-040 d_req continuously re-raised with i_req high, FAIR_MAX=4 -> 5th grant goes to I.
REQ-041 Store d_we=1, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF, d_valid pulse, d_rdata unchanged.
REQ-042 No m_ack, TIMEOUT=64 -> m_req drops after 64 wait cycles, bus_err=1, i_valid with i_rdata=0x08000000.
REQ-043 reset during D_BUSY, then m_ack -> m_req=0 immediately, no d_valid, FSM IDLE.
